// File: rtl/onebit_prog_streamer_if.sv
// Signal bundle between the program loader, its requester, the program store
// and the load port of the one-bit NAND core.
interface onebit_prog_streamer_if #(
  parameter int INSTR_WIDTH = 13,
  parameter int ADDR_WIDTH  = 10
);
  logic                   start;
  logic [ADDR_WIDTH-1:0]  prog_len;
  logic                   mem_rd;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [INSTR_WIDTH-1:0] mem_data;
  logic                   load_en;
  logic                   load_bit;
  logic                   busy;
  logic                   done;
  logic                   error;

  // Loader side: takes the request and read data, drives reads and the core.
  modport master (
    input  start, prog_len, mem_data,
    output mem_rd, mem_addr, load_en, load_bit, busy, done, error
  );

  // Environment side: requester, program store and core.
  modport slave (
    output start, prog_len, mem_data,
    input  mem_rd, mem_addr, load_en, load_bit, busy, done, error
  );
endinterface

// File: rtl/onebit_prog_streamer.sv
// Bit-serial program loader for the one-bit NAND core. Fetches instruction
// words from a program store with one cycle of read latency and shifts them
// LSB first into the core load port. load_en maps to the core en, load_bit to
// inReg[0]; dropping load_en at the end lets the core run from PC 0.
//
// state | meaning
// IDLE  | waiting for start; the only state that samples start/prog_len
// PRIME | read strobe for word 0 is on the bus
// FILL  | word 0 read data is on mem_data; captured at the end of this cycle
// SHIFT | load_en high, one bit per cycle; next word fetched during the tail
// DONE  | stream finished, done pulse, busy drops on exit
// ERR   | prog_len rejected, error pulse
//
// load_en is first high in the third cycle after the edge that accepts start
// and stays high for exactly prog_len*INSTR_WIDTH cycles without a gap.
module onebit_prog_streamer #(
  parameter int INSTR_WIDTH = 13,
  parameter int ADDR_WIDTH  = 10,
  parameter int MAX_INSTR   = 1000
) (
  input logic                    clk,
  input logic                    reset,
  onebit_prog_streamer_if.master bus
);

  localparam int BW = $clog2(INSTR_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(INSTR_WIDTH - 1);
  // Bit index at whose end the next read is issued, so the strobe is visible
  // while bit INSTR_WIDTH-2 is on the wire and data arrives for the last bit.
  localparam logic [BW-1:0] PF_BIT = (INSTR_WIDTH >= 3) ? BW'(INSTR_WIDTH - 3) : '0;
  // With two-bit words the next read must already go out as a word is loaded.
  localparam bit PF_ON_LOAD = (INSTR_WIDTH == 2);
  localparam logic [ADDR_WIDTH:0]   MAX_LEN = (ADDR_WIDTH + 1)'(MAX_INSTR);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO_A   = ADDR_WIDTH'(2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    FILL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0]  word_q;
  logic [BW-1:0]          bit_cnt;
  logic [INSTR_WIDTH-1:0] shifter;

  logic                   mem_rd_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic                   load_en_q;
  logic                   load_bit_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;

  logic len_bad;
  logic last_word;
  logic bit_last;
  logic pf_mid;
  logic pf_first;
  logic pf_reload;

  // Request validation and word/bit position decodes for the sequencer.
  always_comb begin
    len_bad   = (bus.prog_len == '0) || ({1'b0, bus.prog_len} > MAX_LEN);
    last_word = (word_q == len_q - ONE_A);
    bit_last  = (bit_cnt == LAST_BIT);
    pf_mid    = (INSTR_WIDTH >= 3) && (bit_cnt == PF_BIT) && !last_word;
    pf_first  = PF_ON_LOAD && (len_q > ONE_A);
    pf_reload = PF_ON_LOAD &&
                (({1'b0, word_q} + {1'b0, TWO_A}) < {1'b0, len_q});
  end

  // Sequencer: validate the request, fetch word 0, then serialise each word
  // with the following word's read overlapped onto its last bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_q      <= '0;
      word_q     <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      load_en_q  <= 1'b0;
      load_bit_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (len_bad) begin
              state   <= ERR;
              error_q <= 1'b1;
            end else begin
              state      <= PRIME;
              len_q      <= bus.prog_len;
              word_q     <= '0;
              bit_cnt    <= '0;
              busy_q     <= 1'b1;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= '0;
            end
          end
        end

        PRIME: state <= FILL;

        FILL: begin
          state      <= SHIFT;
          shifter    <= bus.mem_data;
          load_en_q  <= 1'b1;
          load_bit_q <= bus.mem_data[0];
          bit_cnt    <= '0;
          if (pf_first) begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ONE_A;
          end
        end

        SHIFT: begin
          if (bit_last) begin
            if (last_word) begin
              state      <= DONE;
              load_en_q  <= 1'b0;
              load_bit_q <= 1'b0;
              done_q     <= 1'b1;
            end else begin
              // Prefetched word is on mem_data now; swap it in with no gap.
              shifter    <= bus.mem_data;
              load_bit_q <= bus.mem_data[0];
              bit_cnt    <= '0;
              word_q     <= word_q + ONE_A;
              if (pf_reload) begin
                mem_rd_q   <= 1'b1;
                mem_addr_q <= word_q + TWO_A;
              end
            end
          end else begin
            shifter    <= shifter >> 1;
            load_bit_q <= shifter[1];
            bit_cnt    <= bit_cnt + BW'(1);
            if (pf_mid) begin
              mem_rd_q   <= 1'b1;
              mem_addr_q <= word_q + ONE_A;
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        ERR: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.load_en  = load_en_q;
  assign bus.load_bit = load_bit_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule
